// File: rtl/softex_lane_gather.sv
// Joins the SoftEx lane result streams into full-width, element-interleaved output beats.
// Optional macro SOFTEX_LANE_GATHER_SKID_EN adds a skid register so lane_ready_o no longer depends on out_ready_i.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | no job; lanes held off
//  RUN     | joining lane beats until the tail beat has left the output
//  DONE    | one-cycle done_o pulse, then back to IDLE

module softex_lane_gather #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned LANE_WIDTH = 64,
    parameter int unsigned ELEM_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic                            start_i,
    input  logic [LEN_WIDTH-1:0]            tot_len_i,
    input  logic [NUM_LANES-1:0]            lane_valid_i,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] lane_data_i,
    output logic [NUM_LANES-1:0]            lane_ready_o,
    output logic                            out_valid_o,
    output logic [NUM_LANES*LANE_WIDTH-1:0] out_data_o,
    output logic [NUM_LANES*LANE_WIDTH/8-1:0] out_strb_o,
    output logic                            out_last_o,
    input  logic                            out_ready_i,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int unsigned DATA_WIDTH = NUM_LANES * LANE_WIDTH;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned EPB        = DATA_WIDTH / ELEM_WIDTH;
    localparam int unsigned ELEM_BYTES = ELEM_WIDTH / 8;
    localparam logic [LEN_WIDTH-1:0] EPB_LEN = LEN_WIDTH'(EPB);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [STRB_WIDTH-1:0] out_strb_q;
    logic                  out_last_q;

    logic                  is_last;
    logic                  job_open;
    logic                  can_load;
    logic                  lane_xfer;
    logic                  out_fire;
    logic [EPB-1:0]        elem_keep;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [STRB_WIDTH-1:0] beat_strb;

    assign is_last  = (rem_q <= EPB_LEN);
    assign job_open = (state_q == ST_RUN) && (rem_q != '0);
    assign out_fire = out_valid_q && out_ready_i;

    // Element k comes from lane k % NUM_LANES, slot k / NUM_LANES; tail elements are zeroed.
    for (genvar k = 0; k < EPB; k++) begin : g_elem
        localparam logic [LEN_WIDTH-1:0] K_LEN = LEN_WIDTH'(k);
        localparam int unsigned SRC_LSB = (k % NUM_LANES) * LANE_WIDTH + (k / NUM_LANES) * ELEM_WIDTH;

        assign elem_keep[k] = !is_last || (K_LEN < rem_q);
        assign beat_data[k*ELEM_WIDTH +: ELEM_WIDTH] =
            elem_keep[k] ? lane_data_i[SRC_LSB +: ELEM_WIDTH] : '0;
        assign beat_strb[k*ELEM_BYTES +: ELEM_BYTES] = {ELEM_BYTES{elem_keep[k]}};
    end

`ifdef SOFTEX_LANE_GATHER_SKID_EN
    logic                  skid_valid_q;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic [STRB_WIDTH-1:0] skid_strb_q;
    logic                  skid_last_q;

    assign can_load = !skid_valid_q;
`else
    assign can_load = !out_valid_q || out_ready_i;
`endif

    // All lanes are consumed together or not at all.
    assign lane_xfer    = job_open && (&lane_valid_i) && can_load;
    assign lane_ready_o = {NUM_LANES{lane_xfer}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (clear_i) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (tot_len_i == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                            rem_d   = tot_len_i;
                        end
                    end
                end
                ST_RUN: begin
                    if (lane_xfer) begin
                        rem_d = is_last ? '0 : (rem_q - EPB_LEN);
                    end
                    if (out_fire && out_last_q) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

`ifdef SOFTEX_LANE_GATHER_SKID_EN
    // A beat joined while the output is stalled parks in the skid register; the skid always drains first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_strb_q  <= '0;
            skid_last_q  <= 1'b0;
        end else if (clear_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_strb_q  <= '0;
            skid_last_q  <= 1'b0;
        end else if (!out_valid_q || out_ready_i) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                out_strb_q   <= skid_strb_q;
                out_last_q   <= skid_last_q;
                skid_valid_q <= 1'b0;
            end else if (lane_xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= beat_data;
                out_strb_q  <= beat_strb;
                out_last_q  <= is_last;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (lane_xfer) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= beat_data;
            skid_strb_q  <= beat_strb;
            skid_last_q  <= is_last;
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (clear_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (lane_xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= beat_data;
            out_strb_q  <= beat_strb;
            out_last_q  <= is_last;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_strb_o  = out_strb_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_softex_lane_gather.sv
// Directed self-checking bench for softex_lane_gather (default parameters: EPB=16, 4 lanes of 4 elements).
// Honours SOFTEX_LANE_GATHER_SKID_EN when predicting backpressure behaviour.

module tb_softex_lane_gather;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clear_i;
    logic         start_i;
    logic [31:0]  tot_len_i;
    logic [3:0]   lane_valid_i;
    logic [255:0] lane_data_i;
    logic [3:0]   lane_ready_o;
    logic         out_valid_o;
    logic [255:0] out_data_o;
    logic [31:0]  out_strb_o;
    logic         out_last_o;
    logic         out_ready_i;
    logic         busy_o;
    logic         done_o;

    int total = 0;
    int bad   = 0;

    softex_lane_gather dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .tot_len_i    (tot_len_i),
        .lane_valid_i (lane_valid_i),
        .lane_data_i  (lane_data_i),
        .lane_ready_o (lane_ready_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_strb_o   (out_strb_o),
        .out_last_o   (out_last_o),
        .out_ready_i  (out_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Lane i slot s carries {id, i, s}; id distinguishes successive beats.
    function automatic logic [255:0] lane_word(input int id);
        logic [255:0] r;
        logic [15:0]  e;
        logic [7:0]   idb;
        logic [3:0]   ln, sl;
        r   = '0;
        idb = id[7:0];
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 4; s++) begin
                ln = i[3:0];
                sl = s[3:0];
                e  = {idb, ln, sl};
                r  = r | (256'(e) << (i * 64 + s * 16));
            end
        end
        return r;
    endfunction

    // Output element k = {id, k%4, k/4}, zero at and beyond nvalid.
    function automatic logic [255:0] exp_beat(input int id, input int nvalid);
        logic [255:0] r;
        logic [15:0]  e;
        logic [7:0]   idb;
        logic [3:0]   ln, sl;
        int           lane_n, slot_n;
        r   = '0;
        idb = id[7:0];
        for (int k = 0; k < 16; k++) begin
            if (k < nvalid) begin
                lane_n = k % 4;
                slot_n = k / 4;
                ln = lane_n[3:0];
                sl = slot_n[3:0];
                e  = {idb, ln, sl};
                r  = r | (256'(e) << (k * 16));
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_strb(input int nvalid);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            if (k < nvalid) r = r | (32'h3 << (2 * k));
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; tot_len_i = '0;
        lane_valid_i = '0; lane_data_i = '0; out_ready_i = 1'b1;
        @(negedge clk_i); #1;
        total++; if ({out_valid_o, out_last_o, busy_o, done_o} !== 4'b0000) begin bad++;
            $display("FAIL reset_flags got=%b exp=0000", {out_valid_o, out_last_o, busy_o, done_o}); end
        total++; if (out_data_o !== '0 || out_strb_o !== '0) begin bad++;
            $display("FAIL reset_data got=%h/%h exp=0/0", out_data_o, out_strb_o); end
        @(negedge clk_i); rst_ni = 1'b1;
        lane_valid_i = 4'hF; lane_data_i = lane_word(9);
        @(negedge clk_i); #1;
        total++; if (lane_ready_o !== 4'h0 || busy_o !== 1'b0) begin bad++;
            $display("FAIL idle_holdoff got=%h busy=%b exp=0 busy=0", lane_ready_o, busy_o); end
        lane_valid_i = '0;
    endtask

    task automatic test_full_beats();
        @(negedge clk_i); start_i = 1'b1; tot_len_i = 32; out_ready_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0; lane_valid_i = 4'hF; lane_data_i = lane_word(1); #1;
        total++; if (lane_ready_o !== 4'hF) begin bad++;
            $display("FAIL full_join got=%h exp=f", lane_ready_o); end
        @(negedge clk_i); lane_data_i = lane_word(2); #1;
        total++; if ({out_valid_o, out_last_o} !== 2'b10) begin bad++;
            $display("FAIL full_b1_flags got=%b exp=10", {out_valid_o, out_last_o}); end
        total++; if (out_data_o !== exp_beat(1, 16)) begin bad++;
            $display("FAIL full_b1_data got=%h exp=%h", out_data_o, exp_beat(1, 16)); end
        total++; if (out_strb_o !== 32'hFFFF_FFFF) begin bad++;
            $display("FAIL full_b1_strb got=%h exp=ffffffff", out_strb_o); end
        @(negedge clk_i); lane_data_i = lane_word(3); #1;
        total++; if ({out_valid_o, out_last_o} !== 2'b11) begin bad++;
            $display("FAIL full_b2_flags got=%b exp=11", {out_valid_o, out_last_o}); end
        total++; if (out_data_o !== exp_beat(2, 16) || out_strb_o !== 32'hFFFF_FFFF) begin bad++;
            $display("FAIL full_b2_data got=%h/%h exp=%h/ffffffff", out_data_o, out_strb_o, exp_beat(2, 16)); end
        total++; if (lane_ready_o !== 4'h0) begin bad++;
            $display("FAIL full_no_extra got=%h exp=0", lane_ready_o); end
        @(negedge clk_i); lane_valid_i = '0; #1;
        total++; if ({done_o, busy_o, out_valid_o} !== 3'b110) begin bad++;
            $display("FAIL full_done got=%b exp=110", {done_o, busy_o, out_valid_o}); end
        @(negedge clk_i); #1;
        total++; if ({done_o, busy_o} !== 2'b00) begin bad++;
            $display("FAIL full_idle got=%b exp=00", {done_o, busy_o}); end
    endtask

    task automatic test_partial_tail();
        @(negedge clk_i); start_i = 1'b1; tot_len_i = 20; out_ready_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0; lane_valid_i = 4'hF; lane_data_i = lane_word(1);
        @(negedge clk_i); lane_data_i = lane_word(2); #1;
        total++; if (out_data_o !== exp_beat(1, 16) || out_last_o !== 1'b0 || out_strb_o !== 32'hFFFF_FFFF) begin bad++;
            $display("FAIL part_b1 got=%h/%h/%b exp=%h/ffffffff/0", out_data_o, out_strb_o, out_last_o, exp_beat(1, 16)); end
        @(negedge clk_i); lane_valid_i = '0; #1;
        total++; if (out_strb_o !== 32'h0000_00FF) begin bad++;
            $display("FAIL part_b2_strb got=%h exp=000000ff", out_strb_o); end
        total++; if (out_data_o !== exp_beat(2, 4)) begin bad++;
            $display("FAIL part_b2_data got=%h exp=%h", out_data_o, exp_beat(2, 4)); end
        total++; if ({out_valid_o, out_last_o} !== 2'b11) begin bad++;
            $display("FAIL part_b2_flags got=%b exp=11", {out_valid_o, out_last_o}); end
        @(negedge clk_i); #1;
        total++; if (done_o !== 1'b1) begin bad++;
            $display("FAIL part_done got=%b exp=1", done_o); end
        @(negedge clk_i);
    endtask

    task automatic test_backpressure();
        int next_id, xfers, got, exp_xfers;
        bit done_seen;
`ifdef SOFTEX_LANE_GATHER_SKID_EN
        exp_xfers = 1;
`else
        exp_xfers = 0;
`endif
        @(negedge clk_i); start_i = 1'b1; tot_len_i = 48; out_ready_i = 1'b0;
        @(negedge clk_i); start_i = 1'b0; lane_valid_i = 4'hF; lane_data_i = lane_word(1); #1;
        total++; if (lane_ready_o !== 4'hF) begin bad++;
            $display("FAIL bp_first_join got=%h exp=f", lane_ready_o); end
        next_id = 2; xfers = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i); lane_data_i = lane_word(next_id); #1;
            total++; if (out_valid_o !== 1'b1 || out_last_o !== 1'b0 || out_data_o !== exp_beat(1, 16)
                         || out_strb_o !== 32'hFFFF_FFFF) begin bad++;
                $display("FAIL bp_hold c=%0d got=%b/%b/%h exp=1/0/%h", c, out_valid_o, out_last_o, out_data_o, exp_beat(1, 16)); end
            if (lane_ready_o == 4'hF) begin xfers++; next_id++; end
        end
        total++; if (xfers !== exp_xfers) begin bad++;
            $display("FAIL bp_lane_xfers got=%0d exp=%0d", xfers, exp_xfers); end
        got = 0; done_seen = 1'b0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            @(negedge clk_i); out_ready_i = 1'b1; lane_data_i = lane_word(next_id); #1;
            if (done_o) done_seen = 1'b1;
            if (out_valid_o) begin
                total++; if (out_data_o !== exp_beat(got + 1, 16) || out_last_o !== (got == 2)) begin bad++;
                    $display("FAIL bp_drain beat=%0d got=%h last=%b exp=%h last=%b", got + 1, out_data_o, out_last_o,
                             exp_beat(got + 1, 16), (got == 2)); end
                got++;
            end
            if (lane_ready_o == 4'hF) next_id++;
        end
        total++; if (got !== 3 || !done_seen) begin bad++;
            $display("FAIL bp_complete got beats=%0d done=%b exp beats=3 done=1", got, done_seen); end
        lane_valid_i = '0;
        @(negedge clk_i);
    endtask

    task automatic test_skewed_lanes();
        @(negedge clk_i); start_i = 1'b1; tot_len_i = 16; out_ready_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0; lane_valid_i = 4'b1011; lane_data_i = lane_word(7);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk_i);
            #1;
            total++; if (lane_ready_o !== 4'h0 || out_valid_o !== 1'b0) begin bad++;
                $display("FAIL skew_wait c=%0d got=%h/%b exp=0/0", c, lane_ready_o, out_valid_o); end
        end
        @(negedge clk_i); lane_valid_i = 4'hF; #1;
        total++; if (lane_ready_o !== 4'hF) begin bad++;
            $display("FAIL skew_join got=%h exp=f", lane_ready_o); end
        @(negedge clk_i); #1;
        total++; if (out_data_o !== exp_beat(7, 16) || {out_valid_o, out_last_o} !== 2'b11 || lane_ready_o !== 4'h0) begin bad++;
            $display("FAIL skew_beat got=%h/%b%b/%h exp=%h/11/0", out_data_o, out_valid_o, out_last_o, lane_ready_o, exp_beat(7, 16)); end
        lane_valid_i = '0;
        @(negedge clk_i); #1;
        total++; if (done_o !== 1'b1) begin bad++;
            $display("FAIL skew_done got=%b exp=1", done_o); end
        @(negedge clk_i);
    endtask

    task automatic test_zero_length();
        bit saw_valid;
        saw_valid = 1'b0;
        @(negedge clk_i); start_i = 1'b1; tot_len_i = 0; lane_valid_i = 4'hF; lane_data_i = lane_word(3);
        @(negedge clk_i); start_i = 1'b0; #1;
        saw_valid |= out_valid_o;
        total++; if ({done_o, busy_o} !== 2'b11) begin bad++;
            $display("FAIL zero_done got=%b exp=11", {done_o, busy_o}); end
        @(negedge clk_i); #1;
        saw_valid |= out_valid_o;
        total++; if ({done_o, busy_o, lane_ready_o} !== 6'b0) begin bad++;
            $display("FAIL zero_idle got=%b exp=000000", {done_o, busy_o, lane_ready_o}); end
        @(negedge clk_i); #1;
        saw_valid |= out_valid_o;
        total++; if (saw_valid !== 1'b0) begin bad++;
            $display("FAIL zero_no_beat got=%b exp=0", saw_valid); end
        lane_valid_i = '0;
    endtask

    task automatic test_clear();
        @(negedge clk_i); start_i = 1'b1; tot_len_i = 48; out_ready_i = 1'b0;
        @(negedge clk_i); start_i = 1'b0; lane_valid_i = 4'hF; lane_data_i = lane_word(4);
        @(negedge clk_i); #1;
        total++; if (out_valid_o !== 1'b1) begin bad++;
            $display("FAIL clr_pre got=%b exp=1", out_valid_o); end
        clear_i = 1'b1; lane_valid_i = '0;
        @(negedge clk_i); clear_i = 1'b0; lane_valid_i = 4'hF; #1;
        total++; if ({out_valid_o, busy_o, lane_ready_o} !== 6'b0) begin bad++;
            $display("FAIL clr_after got=%b exp=000000", {out_valid_o, busy_o, lane_ready_o}); end
        clear_i = 1'b1; start_i = 1'b1; tot_len_i = 16; lane_valid_i = '0;
        @(negedge clk_i); clear_i = 1'b0; start_i = 1'b0; #1;
        total++; if ({busy_o, done_o} !== 2'b00) begin bad++;
            $display("FAIL clr_priority got=%b exp=00", {busy_o, done_o}); end
        start_i = 1'b1; tot_len_i = 16; out_ready_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0; lane_valid_i = 4'hF; lane_data_i = lane_word(5); #1;
        total++; if (lane_ready_o !== 4'hF) begin bad++;
            $display("FAIL clr_restart_join got=%h exp=f", lane_ready_o); end
        @(negedge clk_i); lane_valid_i = '0; #1;
        total++; if (out_data_o !== exp_beat(5, 16) || {out_valid_o, out_last_o} !== 2'b11) begin bad++;
            $display("FAIL clr_restart_beat got=%h/%b exp=%h/11", out_data_o, {out_valid_o, out_last_o}, exp_beat(5, 16)); end
        @(negedge clk_i); #1;
        total++; if ({done_o, out_valid_o} !== 2'b10) begin bad++;
            $display("FAIL clr_restart_done got=%b exp=10", {done_o, out_valid_o}); end
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_full_beats();
        test_partial_tail();
        test_backpressure();
        test_skewed_lanes();
        test_zero_length();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
